// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning HI/LO, with multi-cycle busy latency.
// Define MDU_MADD_EN to enable madd/maddu (ops 9/10); otherwise those ops are reserved.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_out
);
  localparam logic [3:0] MC        = 4'(MULT_CYCLES);
  localparam logic [3:0] DC        = 4'(DIV_CYCLES);
  localparam logic [3:0] OP_MULT   = 4'd1;
  localparam logic [3:0] OP_MULTU  = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_DIVU   = 4'd4;
  localparam logic [3:0] OP_MTHI   = 4'd5;
  localparam logic [3:0] OP_MTLO   = 4'd6;
  localparam logic [3:0] OP_MFHI   = 4'd7;
  localparam logic [3:0] OP_MFLO   = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD   = 4'd9;
  localparam logic [3:0] OP_MADDU  = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_madd, is_mul, is_div, mul_sgn, div_sgn, div_ovf;
  logic [63:0] prod;
  logic [31:0] den, quo, rem;

  // Operand datapath: evaluated every cycle, only captured into shadow on the start edge.
  always_comb begin
    is_madd = 1'b0;
    mul_sgn = (mdu_op == OP_MULT);
`ifdef MDU_MADD_EN
    is_madd = (mdu_op == OP_MADD) || (mdu_op == OP_MADDU);
    mul_sgn = (mdu_op == OP_MULT) || (mdu_op == OP_MADD);
`endif
    is_mul  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) || is_madd;
    is_div  = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    // Low 64 bits of a product of sign-extended operands equal the signed product.
    if (mul_sgn)
      prod = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    else
      prod = {32'd0, rs_data} * {32'd0, rt_data};
    if (is_madd)
      prod = prod + {hi_q, lo_q};

    div_sgn = (mdu_op == OP_DIV);
    div_ovf = div_sgn && (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
    // Dividing by 1 yields exactly the required overflow result and keeps /0 X-free.
    den = ((rt_data == 32'd0) || div_ovf) ? 32'd1 : rt_data;
    if (div_sgn) begin
      quo = $signed(rs_data) / $signed(den);
      rem = $signed(rs_data) % $signed(den);
    end else begin
      quo = rs_data / den;
      rem = rs_data % den;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    wr_d     = wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: if (start) begin
        if (is_mul) begin
          state_d  = MUL;
          cnt_d    = MC;
          shadow_d = prod;
          wr_d     = 1'b1;
        end else if (is_div) begin
          state_d  = DIV;
          cnt_d    = DC;
          shadow_d = {rem, quo};
          wr_d     = (rt_data != 32'd0);
        end else if (mdu_op == OP_MTHI) begin
          hi_d = rs_data;
        end else if (mdu_op == OP_MTLO) begin
          lo_d = rs_data;
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = shadow_q[63:32];
            lo_d = shadow_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      shadow_q <= 64'd0;
      wr_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      wr_q     <= wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign mdu_out = (mdu_op == OP_MFHI) ? hi_q :
                   (mdu_op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed + randomized checks of e_mdu against a cycle-level HI/LO reference model.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy;
  logic [31:0] hi_out, lo_out, mdu_out;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_busy = 0;
  logic [63:0] m_res = 64'd0;
  bit          m_wr = 1'b0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy),
    .hi_out(hi_out), .lo_out(lo_out), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    bit madd_en;
    ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
    madd_en = 1'b0;
`ifdef MDU_MADD_EN
    madd_en = 1'b1;
`endif
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && m_wr) {m_hi, m_lo} = m_res;
    end else if (st) begin
      case (op)
        4'd1: begin m_res = 64'(sa * sb); m_wr = 1; m_busy = 5; end
        4'd2: begin m_res = 64'(ua * ub); m_wr = 1; m_busy = 5; end
        4'd9, 4'd10: if (madd_en) begin
          m_res = {m_hi, m_lo} + ((op == 4'd9) ? 64'(sa * sb) : 64'(ua * ub));
          m_wr = 1; m_busy = 5;
        end
        4'd3, 4'd4: begin
          m_busy = 10;
          m_wr = (b != 0);
          if (b != 0) begin
            if (op == 4'd3) begin q = sa / sb; r = sa % sb; end
            else begin q = longint'(ua / ub); r = longint'(ua % ub); end
            m_res = {32'(r), 32'(q)};
          end
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // one cycle: drive at negedge, check read mux, clock, check state at next negedge
  task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = st; mdu_op = op; rs_data = a; rt_data = b;
    #1;
    chk("mdu_out", {32'd0, mdu_out}, {32'd0, (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0});
    @(posedge clk);
    model_edge(st, op, a, b);
    @(negedge clk);
    chk("busy", {63'd0, busy}, {63'd0, m_busy > 0});
    chk("hilo", {hi_out, lo_out}, {m_hi, m_lo});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic hit_reset();
    start = 1'b0; mdu_op = 4'd0;
    reset = 1'b1;
    #1;
    m_hi = 0; m_lo = 0; m_busy = 0; m_wr = 0; m_res = 0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1;
    chk("por_busy", {63'd0, busy}, 64'd0);
    chk("por_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // reset in the middle of a divide aborts it
    step(1, 4'd3, 32'd100, 32'd7);
    idle(2);
    hit_reset();
    idle(12);
    chk("rst_div_hilo", {hi_out, lo_out}, 64'd0);

    // mult / multu
    step(1, 4'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy", {63'd0, busy}, 64'd1);
    idle(4);
    chk("mult_busy_last", {63'd0, busy}, 64'd1);
    idle(1);
    chk("mult_done", {63'd0, busy}, 64'd0);
    chk("mult", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
    step(1, 4'd2, 32'hFFFF_FFFE, 32'd3);
    idle(5);
    chk("multu", {hi_out, lo_out}, 64'h0000_0002_FFFF_FFFA);

    // div / divu
    step(1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(9);
    chk("div_busy_last", {63'd0, busy}, 64'd1);
    idle(1);
    chk("div", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    step(1, 4'd4, 32'd7, 32'd2);
    idle(10);
    chk("divu", {hi_out, lo_out}, 64'h0000_0001_0000_0003);

    // overflow divide
    step(1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    chk("div_ovf", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

    // divide by zero leaves HI/LO alone
    step(1, 4'd5, 32'h11, 32'd0);
    step(1, 4'd6, 32'h22, 32'd0);
    step(1, 4'd3, 32'd5, 32'd0);
    idle(9);
    chk("div0_busy", {63'd0, busy}, 64'd1);
    idle(1);
    chk("div0", {hi_out, lo_out}, 64'h0000_0011_0000_0022);

    // mthi then mflo / mfhi
    step(1, 4'd5, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    step(1, 4'd8, 32'd0, 32'd0);
    mdu_op = 4'd8; #1;
    chk("mflo", {32'd0, mdu_out}, 64'h22);
    mdu_op = 4'd7; #1;
    chk("mfhi", {32'd0, mdu_out}, 64'hDEAD_BEEF);
    step(1, 4'd7, 32'd0, 32'd0);

    // second start while busy is ignored
    step(1, 4'd3, 32'd100, 32'd7);
    idle(3);
    step(1, 4'd3, 32'd9, 32'd2);
    step(1, 4'd5, 32'h5555_5555, 32'd0);
    idle(5);
    chk("div_ignore", {hi_out, lo_out}, 64'h0000_0002_0000_000E);

    // maddu
    step(1, 4'd5, 32'd0, 32'd0);
    step(1, 4'd6, 32'hFFFF_FFFF, 32'd0);
    step(1, 4'd10, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    chk("maddu_busy", {63'd0, busy}, 64'd1);
    idle(5);
    chk("maddu", {hi_out, lo_out}, 64'h0000_0001_0000_0000);
`else
    chk("maddu_busy", {63'd0, busy}, 64'd0);
    idle(5);
    chk("maddu", {hi_out, lo_out}, 64'h0000_0000_FFFF_FFFF);
`endif

    // randomized traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) hit_reset();
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick());
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
